ps2_keymap_decoder: RTL and testbench

Parametrised PS/2 scancode-set-2 decoder that turns the byte stream from `PS2_Controller` into per-key held levels and one-cycle make/break/repeat pulses for a configurable table of keys. It handles the E0 (extended) and F0 (break) prefixes, swallows the 8-byte Pause sequence, and recovers from stalled prefixes with a timeout. It sits between `PS2_Controller` and game control logic, replacing ad-hoc per-key flag registers.

---
 rtl/ps2_keymap_decoder_if.sv | 15 +
 rtl/ps2_keymap_decoder.sv | 212 +++++++++++++++++++++
 tb/tb_ps2_keymap_decoder.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_keymap_decoder_if.sv
// Byte stream from the PS/2 receiver into the keymap decoder.
interface ps2_keymap_decoder_if;
  logic [7:0] received_data;
  logic       received_data_en;

  modport master (
    output received_data,
    output received_data_en
  );

  modport slave (
    input received_data,
    input received_data_en
  );
endinterface

// File: rtl/ps2_keymap_decoder.sv
// PS/2 scancode-set-2 decoder: E0/F0 prefix handling, Pause swallowing,
// prefix timeout, and per-key held levels with make/break/repeat pulses.
module ps2_keymap_decoder #(
  parameter int                    NUM_KEYS       = 4,
  parameter logic [9*NUM_KEYS-1:0] KEY_CODES      = {9'h175, 9'h174, 9'h16B, 9'h05A},
  parameter int                    TIMEOUT_CYCLES = 2_500_000
) (
  input  logic                      CLOCK_50,
  input  logic                      resetn,
  ps2_keymap_decoder_if.slave       ps2,
  output logic [NUM_KEYS-1:0]       key_held,
  output logic [NUM_KEYS-1:0]       key_make,
  output logic [NUM_KEYS-1:0]       key_break,
  output logic [NUM_KEYS-1:0]       key_repeat,
  output logic                      any_held,
  output logic                      unmapped,
  output logic                      seq_error
);

  localparam int            TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_ONE   = TW'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXT     = 3'd1,
    S_BRK     = 3'd2,
    S_EXT_BRK = 3'd3,
    S_PAUSE   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    skip_q, skip_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [TW-1:0] tmo_inc_s;

  logic          ev_make_s;
  logic          ev_break_s;
  logic [8:0]    ev_code_s;
  logic          err_s;

  logic [NUM_KEYS-1:0] match_s;

  logic [NUM_KEYS-1:0] held_q, held_d;
  logic [NUM_KEYS-1:0] make_q, make_d;
  logic [NUM_KEYS-1:0] brk_q, brk_d;
  logic [NUM_KEYS-1:0] rep_q, rep_d;
  logic                any_q, any_d;
  logic                unm_q, unm_d;
  logic                err_q, err_d;

  logic [7:0] data_s;
  logic       strobe_s;

  assign data_s   = ps2.received_data;
  assign strobe_s = ps2.received_data_en;

  // Prefix state machine: classify each byte into make/break events, errors or swallowed Pause bytes; run the prefix timeout.
  always_comb begin
    state_d    = state_q;
    skip_d     = skip_q;
    tmo_d      = tmo_q;
    tmo_inc_s  = tmo_q;
    ev_make_s  = 1'b0;
    ev_break_s = 1'b0;
    ev_code_s  = 9'h000;
    err_s      = 1'b0;
    if (strobe_s) begin
      // A byte always wins over a timeout expiring in the same cycle.
      tmo_d = '0;
      case (state_q)
        S_IDLE: begin
          case (data_s)
            8'hE0:   state_d = S_EXT;
            8'hF0:   state_d = S_BRK;
            8'hE1: begin
              state_d = S_PAUSE;
              skip_d  = 3'd7;
            end
            default: begin
              ev_make_s = 1'b1;
              ev_code_s = {1'b0, data_s};
            end
          endcase
        end
        S_EXT: begin
          case (data_s)
            8'hF0:        state_d = S_EXT_BRK;
            8'hE0, 8'hE1: begin
              err_s   = 1'b1;
              state_d = S_IDLE;
            end
            default: begin
              ev_make_s = 1'b1;
              ev_code_s = {1'b1, data_s};
              state_d   = S_IDLE;
            end
          endcase
        end
        S_BRK, S_EXT_BRK: begin
          case (data_s)
            8'hE0, 8'hF0, 8'hE1: begin
              err_s   = 1'b1;
              state_d = S_IDLE;
            end
            default: begin
              ev_break_s = 1'b1;
              ev_code_s  = {(state_q == S_EXT_BRK), data_s};
              state_d    = S_IDLE;
            end
          endcase
        end
        S_PAUSE: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_PAUSE;
          end
        end
        default: begin
          state_d = S_IDLE;
          skip_d  = 3'd0;
        end
      endcase
    end else if (state_q != S_IDLE) begin
      // Saturating count of idle cycles spent waiting inside a prefix.
      if (tmo_q == {TW{1'b1}}) begin
        tmo_inc_s = tmo_q;
      end else begin
        tmo_inc_s = tmo_q + TMO_ONE;
      end
      if (tmo_inc_s == TMO_LIMIT) begin
        state_d = S_IDLE;
        skip_d  = 3'd0;
        tmo_d   = '0;
        err_s   = 1'b1;
      end else begin
        tmo_d = tmo_inc_s;
      end
    end else begin
      tmo_d = '0;
    end
  end

  // Compare the decoded {ext,code} against every table entry in parallel.
  always_comb begin
    match_s = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      match_s[i] = (ev_code_s == KEY_CODES[9*i +: 9]);
    end
  end

  // Apply make/break events to the held levels and form the next pulse values.
  always_comb begin
    held_d = held_q;
    make_d = '0;
    brk_d  = '0;
    rep_d  = '0;
    unm_d  = 1'b0;
    err_d  = err_s;
    if (ev_make_s) begin
      make_d = match_s & ~held_q;
      rep_d  = match_s & held_q;
      held_d = held_q | match_s;
      unm_d  = (match_s == '0);
    end else if (ev_break_s) begin
      brk_d  = match_s & held_q;
      held_d = held_q & ~match_s;
      unm_d  = (match_s == '0);
    end else begin
      held_d = held_q;
    end
    any_d = |held_d;
  end

  // State, counters and all registered outputs.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      skip_q  <= 3'd0;
      tmo_q   <= '0;
      held_q  <= '0;
      make_q  <= '0;
      brk_q   <= '0;
      rep_q   <= '0;
      any_q   <= 1'b0;
      unm_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      tmo_q   <= tmo_d;
      held_q  <= held_d;
      make_q  <= make_d;
      brk_q   <= brk_d;
      rep_q   <= rep_d;
      any_q   <= any_d;
      unm_q   <= unm_d;
      err_q   <= err_d;
    end
  end

  assign key_held   = held_q;
  assign key_make   = make_q;
  assign key_break  = brk_q;
  assign key_repeat = rep_q;
  assign any_held   = any_q;
  assign unmapped   = unm_q;
  assign seq_error  = err_q;

endmodule

// File: tb/tb_ps2_keymap_decoder.sv
// Randomised and directed bench for ps2_keymap_decoder against a
// byte-sequence reference model.
module tb_ps2_keymap_decoder;
  localparam int NK  = 4;
  localparam int TMO = 16;

  logic          clk;
  logic          resetn;
  logic [NK-1:0] key_held, key_make, key_break, key_repeat;
  logic          any_held, unmapped, seq_error;

  ps2_keymap_decoder_if rx ();

  ps2_keymap_decoder #(
    .NUM_KEYS      (NK),
    .KEY_CODES     ({9'h175, 9'h174, 9'h16B, 9'h05A}),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLOCK_50  (clk),
    .resetn    (resetn),
    .ps2       (rx),
    .key_held  (key_held),
    .key_make  (key_make),
    .key_break (key_break),
    .key_repeat(key_repeat),
    .any_held  (any_held),
    .unmapped  (unmapped),
    .seq_error (seq_error)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: key table, pending prefix bytes, Pause skip count, wait time.
  int unsigned key_tab [NK] = '{32'h05A, 32'h16B, 32'h174, 32'h175};
  logic [7:0]  pending [$];
  int          pause_left;
  int          wait_cyc;
  bit [NK-1:0] m_held, e_make, e_brk, e_rep;
  bit          e_unm, e_err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  function automatic logic [18:0] obs_vec();
    return {key_held, key_make, key_break, key_repeat, any_held, unmapped, seq_error};
  endfunction

  function automatic logic [18:0] exp_vec();
    return {m_held, e_make, e_brk, e_rep, (m_held != '0), e_unm, e_err};
  endfunction

  function automatic void clear_pulses();
    e_make = '0; e_brk = '0; e_rep = '0; e_unm = 1'b0; e_err = 1'b0;
  endfunction

  function automatic void model_reset();
    clear_pulses();
    pending.delete();
    pause_left = 0;
    wait_cyc   = 0;
    m_held     = '0;
  endfunction

  function automatic void model_event(bit is_break, int unsigned code);
    bit hit = 1'b0;
    for (int i = 0; i < NK; i++) begin
      if (key_tab[i] == code) begin
        hit = 1'b1;
        if (!is_break) begin
          if (m_held[i]) e_rep[i] = 1'b1;
          else begin e_make[i] = 1'b1; m_held[i] = 1'b1; end
        end else if (m_held[i]) begin
          e_brk[i] = 1'b1; m_held[i] = 1'b0;
        end
      end
    end
    if (!hit) e_unm = 1'b1;
  endfunction

  function automatic void model_byte(logic [7:0] b);
    bit is_prefix;
    clear_pulses();
    wait_cyc  = 0;
    is_prefix = (b == 8'hE0) || (b == 8'hF0) || (b == 8'hE1);
    if (pause_left > 0) begin
      pause_left--;
    end else if (pending.size() == 0) begin
      if (b == 8'hE1) pause_left = 7;
      else if (b == 8'hE0 || b == 8'hF0) pending.push_back(b);
      else model_event(1'b0, int'(b));
    end else if (pending[pending.size()-1] == 8'hE0) begin
      if (b == 8'hF0) pending.push_back(b);
      else begin
        if (is_prefix) e_err = 1'b1;
        else model_event(1'b0, 32'h100 + int'(b));
        pending.delete();
      end
    end else begin
      if (is_prefix) e_err = 1'b1;
      else model_event(1'b1, (pending[0] == 8'hE0 ? 32'h100 : 32'h0) + int'(b));
      pending.delete();
    end
  endfunction

  function automatic void model_idle();
    clear_pulses();
    if (pending.size() > 0 || pause_left > 0) begin
      wait_cyc++;
      if (wait_cyc == TMO) begin
        e_err = 1'b1;
        pending.delete();
        pause_left = 0;
        wait_cyc   = 0;
      end
    end
  endfunction

  task automatic drive_byte(input logic [7:0] b);
    rx.received_data    = b;
    rx.received_data_en = 1'b1;
    @(posedge clk);
    #1;
    rx.received_data_en = 1'b0;
    model_byte(b);
  endtask

  task automatic drive_idle();
    @(posedge clk);
    #1;
    model_idle();
  endtask

  task automatic test_reset();
    rx.received_data    = 8'h00;
    rx.received_data_en = 1'b0;
    resetn = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (obs_vec() !== 19'h0) $display("FAIL reset outputs: got %h expected %h", obs_vec(), 19'h0);
    else pass_cnt++;
    @(negedge clk);
    resetn = 1'b1;
    drive_idle();
  endtask

  task automatic test_basic();
    logic [7:0] seq [3] = '{8'h5A, 8'hF0, 8'h5A};
    for (int i = 0; i < 3; i++) begin
      drive_byte(seq[i]);
      total_cnt++;
      if (obs_vec() !== exp_vec()) $display("FAIL basic step %0d: got %h expected %h", i, obs_vec(), exp_vec());
      else pass_cnt++;
      if (i == 0) begin
        total_cnt++;
        if (key_held !== 4'b0001 || key_make !== 4'b0001)
          $display("FAIL basic make0: got held %b make %b expected 0001 0001", key_held, key_make);
        else pass_cnt++;
        drive_idle();
        total_cnt++;
        if (key_make !== 4'b0000) $display("FAIL basic make0 width: got %b expected 0000", key_make);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (key_held !== 4'b0000 || key_break !== 4'b0001)
      $display("FAIL basic break0: got held %b break %b expected 0000 0001", key_held, key_break);
    else pass_cnt++;
  endtask

  task automatic test_extended();
    logic [7:0] seq [6] = '{8'hE0, 8'h6B, 8'hE0, 8'hF0, 8'h6B, 8'h6B};
    for (int i = 0; i < 6; i++) begin
      drive_byte(seq[i]);
      total_cnt++;
      if (obs_vec() !== exp_vec()) $display("FAIL extended step %0d: got %h expected %h", i, obs_vec(), exp_vec());
      else pass_cnt++;
    end
    total_cnt++;
    if (unmapped !== 1'b1 || key_held !== 4'b0000)
      $display("FAIL extended plain6B: got unmapped %b held %b expected 1 0000", unmapped, key_held);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [12] = '{8'h74, 8'hE0, 8'h74, 8'hE0, 8'h74, 8'h5A, 8'hE0, 8'h75,
                             8'hE0, 8'hF0, 8'h74, 8'hAA};
    for (int i = 0; i < 12; i++) begin
      drive_byte(seq[i]);
      total_cnt++;
      if (obs_vec() !== exp_vec()) $display("FAIL back_to_back step %0d: got %h expected %h", i, obs_vec(), exp_vec());
      else pass_cnt++;
      if (i == 4) begin
        total_cnt++;
        if (key_repeat !== 4'b0100 || key_make !== 4'b0000)
          $display("FAIL back_to_back repeat2: got rep %b make %b expected 0100 0000", key_repeat, key_make);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (key_held !== 4'b1001 || any_held !== 1'b1)
      $display("FAIL back_to_back held: got %b any %b expected 1001 1", key_held, any_held);
    else pass_cnt++;
  endtask

  task automatic test_pause();
    logic [7:0] seq [11] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77,
                             8'hF0, 8'h5A, 8'h5A};
    for (int i = 0; i < 11; i++) begin
      drive_byte(seq[i]);
      total_cnt++;
      if (obs_vec() !== exp_vec()) $display("FAIL pause step %0d: got %h expected %h", i, obs_vec(), exp_vec());
      else pass_cnt++;
    end
    total_cnt++;
    if (key_make !== 4'b0001) $display("FAIL pause after: got make %b expected 0001", key_make);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int errs = 0;
    drive_byte(8'hE0);
    for (int c = 0; c < TMO + 2; c++) begin
      drive_idle();
      if (seq_error === 1'b1) errs++;
      total_cnt++;
      if (obs_vec() !== exp_vec()) $display("FAIL timeout cycle %0d: got %h expected %h", c, obs_vec(), exp_vec());
      else pass_cnt++;
    end
    total_cnt++;
    if (errs != 1) $display("FAIL timeout pulses: got %0d expected 1", errs);
    else pass_cnt++;
    drive_byte(8'h6B);
    total_cnt++;
    if (unmapped !== 1'b1) $display("FAIL timeout then6B: got unmapped %b expected 1", unmapped);
    else pass_cnt++;
    drive_byte(8'hF0);
    drive_byte(8'hE0);
    total_cnt++;
    if (seq_error !== 1'b1) $display("FAIL F0E0 error: got %b expected 1", seq_error);
    else pass_cnt++;
    // Byte arriving exactly when the wait would expire is decoded normally.
    drive_byte(8'hE0);
    repeat (TMO - 1) drive_idle();
    drive_byte(8'h6B);
    total_cnt++;
    if (obs_vec() !== exp_vec() || key_make[1] !== 1'b1)
      $display("FAIL byte_wins: got %h expected %h", obs_vec(), exp_vec());
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    drive_byte(8'h5A);
    drive_byte(8'hE0);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    model_reset();
    total_cnt++;
    if (obs_vec() !== 19'h0) $display("FAIL reset_mid outputs: got %h expected %h", obs_vec(), 19'h0);
    else pass_cnt++;
    @(negedge clk);
    resetn = 1'b1;
    drive_byte(8'h6B);
    total_cnt++;
    if (obs_vec() !== exp_vec() || unmapped !== 1'b1)
      $display("FAIL reset_mid 6B: got %h expected %h", obs_vec(), exp_vec());
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [7:0] pool [10] = '{8'h5A, 8'h6B, 8'h74, 8'h75, 8'hE0, 8'hF0, 8'hE1, 8'hAA, 8'hFA, 8'h12};
    logic [7:0] b;
    int gap;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) b = 8'($urandom);
      else b = pool[$urandom_range(0, 9)];
      drive_byte(b);
      total_cnt++;
      if (obs_vec() !== exp_vec()) $display("FAIL random byte %0d (%h): got %h expected %h", n, b, obs_vec(), exp_vec());
      else pass_cnt++;
      gap = ($urandom_range(0, 15) == 0) ? $urandom_range(10, 20) : $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        drive_idle();
        total_cnt++;
        if (obs_vec() !== exp_vec()) $display("FAIL random idle %0d.%0d: got %h expected %h", n, g, obs_vec(), exp_vec());
        else pass_cnt++;
      end
    end
  endtask

  // Test sequence and summary.
  initial begin
    test_reset();
    test_basic();
    test_extended();
    test_back_to_back();
    test_pause();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
